neighbor_builder: RTL and testbench
===================================

# neighbor_builder

Builds the per-vertex neighbour table consumed by `averager`. Reads the face list from object RAM and, for every face edge, records each endpoint in the other endpoint's neighbour slot in neighbour RAM, without duplicates. Runs once per subdivision pass, before `averager`. Its `done` pulse may drive `averager.start` directly.

## Interface
- `MAX_NEIGHBOR_COUNT`, default 10: words per vertex slot in neighbour RAM, including the count word. Must match `averager`.
- `ADDR_WIDTH`, default 9: RAM address width. Shared define.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock. All state updates on negedge, matching the RAM timing `averager` uses.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a build. Sampled only in IDLE.
- `vertex_count` in 32: number of vertices.
- `face_count` in 32: number of triangles.
- `RAM_OBJ_Do` in 32: object RAM read data. Valid one clock after its address is driven.
- `RAM_NBR_Do` in 32: neighbour RAM read data, same latency.
- `RAM_OBJ_EN`, `RAM_NBR_EN` out 1: RAM enables.
- `RAM_OBJ_A`, `RAM_NBR_A` out `ADDR_WIDTH`: RAM addresses.
- `RAM_OBJ_WE`, `RAM_NBR_WE` out 4: byte write enables. `RAM_OBJ_WE` is always 0.
- `RAM_OBJ_Di`, `RAM_NBR_Di` out 32: write data. `RAM_OBJ_Di` is always 0.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse when the build completes.
- `overflow` out 1: sticky. Set when an insert was dropped because the slot was full. Cleared on `start` or `rst`.
- `bad_index` out 1: sticky. Set when a face was skipped because an index was out of range. Cleared on `start` or `rst`.

## Operation
Memory layout:
- Object RAM:
  - vertex v (1-indexed) occupies words 3(v−1)+1 .. 3(v−1)+3.
  - face f (0-indexed) occupies words 3·vertex_count+1+3f .. +2, holding 1-indexed vertex indices a, b, c.
- Neighbour RAM:
  - slot for vertex v starts at (v−1)·MAX_NEIGHBOR_COUNT.
  - word 0 is the count; words 1..count are 1-indexed neighbour indices.

States:
- IDLE: all enables, WE and `busy` are 0. On `start`: clear the flags, set `busy`, go to CLEAR (or DONE if vertex_count == 0).
- CLEAR: write 0 to the count word of every slot, one slot per cycle. Then go to FACE_RD, or DONE if face_count == 0.
- FACE_RD: read a, b, c from three consecutive addresses, with a one-cycle pipelined read latency. If any index is 0 or greater than vertex_count: set `bad_index` and skip to the next face. Otherwise go to INS.
- INS: run six directed inserts (u→w) in fixed order: a→b, b→a, b→c, c→b, c→a, a→c. Each insert:
  - CNT_RD: read slot(u) word 0 to get n.
  - SCAN: read words 1..n and compare each with w. On a match, the insert is finished with no writes.
  - If no match and n == MAX_NEIGHBOR_COUNT−1: set `overflow`, no writes.
  - Otherwise, APPEND: write w at word n+1, then CNT_WR: write n+1 to word 0.
- After the sixth insert: advance to the next face. After the last face: go to DONE.
- DONE: pulse `done` for one cycle, drop `busy`, return to IDLE.

Arithmetic and width rules:
- Address arithmetic is computed in 32 bits and truncated to `ADDR_WIDTH`.
- Index comparisons use the full 32 bits.
- Counts are unsigned.

Boundary behaviour:
- `start` while busy: ignored.
- Degenerate face (a == b): the self-insert u→u is performed like any other insert. Callers must not supply degenerate faces; the bench does not check this case.
- `rst` mid-build: outputs return to reset values immediately. RAM contents are undefined until the next complete build.

## Timing
- Reset values: every output 0, state IDLE.
- `busy` rises on the negedge after `start` is sampled.
- CLEAR takes vertex_count cycles.
- FACE_RD takes 4 cycles.
- Each insert takes 2 + n cycles to read, plus 2 cycles if it appends.
- Worst-case build: vertex_count + face_count·(4 + 6·(MAX_NEIGHBOR_COUNT+3)) + 2 cycles.
- Reads issue one address per cycle. Data is consumed on the following negedge.
- A write asserts WE for exactly one cycle, with address and data stable in that cycle.

## Structure
- Shared package `subdiv_pkg` holds:
  - `ADDR_WIDTH`, `Q_ONE`
  - the slot-address function `slot_base(v)`
  - the vertex-address function `vtx_addr(v)`
  - the state enum
- `averager` should import the same package.
- One natural sub-module: `nbr_insert`, the u→w insert FSM (CNT_RD/SCAN/APPEND/CNT_WR). Its handshake is `req`/`ack`, and it returns a `full` flag.

## Test plan
- Single triangle: vertex_count=3, face (1,2,3).
  - Slot 1 = {2: 2,3}, slot 2 = {2: 1,3}, slot 3 = {2: 2,1}.
  - `done` pulses once; `overflow` = `bad_index` = 0.
- Quad from two triangles (1,2,3),(1,3,4): slot 1 = {3: 2,3,4}, slot 3 = {3: 2,1,4}, slot 2 = {2: 1,3}, slot 4 = {2: 3,1}. The shared edge is not duplicated.
- Stale data: neighbour RAM prefilled with 0xFFFFFFFF, then rerun the single-triangle case. Results are identical to the clean-RAM run.
- Overflow: MAX_NEIGHBOR_COUNT=4, fan of 4 triangles around vertex 1 (faces (1,2,3),(1,3,4),(1,4,5),(1,5,6)).
  - Slot 1 count stops at 3, holding {2, 3, 4}.
  - `overflow` = 1; other slots are correct.
- Bad index: faces (0,2,3),(1,2,3) with vertex_count=3. The first face is skipped and `bad_index` = 1; the tables match the single-triangle case.
- Reset mid-build: assert `rst` during SCAN. All outputs are 0 in the same cycle. A subsequent `start` completes a correct build.

Source files
------------

// File: rtl/subdiv_pkg.sv
// subdiv_pkg: shared constants, state encodings and RAM address helpers
// for the subdivision blocks (neighbor_builder, averager).
package subdiv_pkg;
    localparam int ADDR_WIDTH = 9;
    localparam logic [31:0] Q_ONE = 32'h0001_0000;

    typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_FACE_RD, ST_INS, ST_DONE} state_e;
    typedef enum logic [2:0] {IS_IDLE, IS_SCAN, IS_DEC, IS_APPEND, IS_CNT_WR} ins_state_e;

    // Vertices are 1-indexed; slot v starts at (v-1)*max_nbr.
    function automatic logic [31:0] slot_base(input logic [31:0] v, input int max_nbr);
        return (v - 32'd1) * 32'(max_nbr);
    endfunction

    function automatic logic [31:0] vtx_addr(input logic [31:0] v);
        return 32'd3 * (v - 32'd1) + 32'd1;
    endfunction
endpackage

// File: rtl/nbr_insert.sv
// nbr_insert: one directed neighbour insert u->w into neighbour RAM.
// In IDLE a pending req is already the count read, so inserts run back to back.
module nbr_insert #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH = subdiv_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [31:0]           u,
    input  logic [31:0]           w,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  ack,
    output logic                  full,
    output logic                  en,
    output logic [ADDR_WIDTH-1:0] a,
    output logic [3:0]            we,
    output logic [31:0]           di
);
    import subdiv_pkg::*;

    ins_state_e r_state, w_next;
    logic [31:0] r_n, r_i, w_base;
    logic        r_match, w_full, w_hit;

    assign w_base = slot_base(u, MAX_NEIGHBOR_COUNT);
    assign w_hit  = RAM_NBR_Do == w;
    assign w_full = !r_match && r_n >= 32'(MAX_NEIGHBOR_COUNT - 1);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IS_IDLE:   w_next = !req ? IS_IDLE : (RAM_NBR_Do == 32'd0) ? IS_DEC : IS_SCAN;
            // The slot-size bound keeps a corrupt count from scanning into other slots.
            IS_SCAN:   w_next = (w_hit || r_i >= r_n || r_i >= 32'(MAX_NEIGHBOR_COUNT - 1)) ? IS_DEC : IS_SCAN;
            IS_DEC:    w_next = (r_match || w_full) ? IS_IDLE : IS_APPEND;
            IS_APPEND: w_next = IS_CNT_WR;
            default:   w_next = IS_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IS_IDLE;
            r_n     <= '0;
            r_i     <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IS_IDLE && req) begin
                r_n     <= RAM_NBR_Do;
                r_i     <= 32'd1;
                r_match <= 1'b0;
            end
            if (r_state == IS_SCAN) begin
                r_i <= r_i + 32'd1;
                if (w_hit) r_match <= 1'b1;
            end
        end
    end

    assign en   = (r_state == IS_IDLE && req) || r_state == IS_SCAN || r_state == IS_APPEND || r_state == IS_CNT_WR;
    assign a    = r_state == IS_SCAN   ? ADDR_WIDTH'(w_base + r_i) :
                  r_state == IS_APPEND ? ADDR_WIDTH'(w_base + r_n + 32'd1) : ADDR_WIDTH'(w_base);
    assign we   = (r_state == IS_APPEND || r_state == IS_CNT_WR) ? 4'hF : 4'h0;
    assign di   = r_state == IS_APPEND ? w : r_state == IS_CNT_WR ? r_n + 32'd1 : 32'd0;
    assign ack  = (r_state == IS_DEC && (r_match || w_full)) || r_state == IS_CNT_WR;
    assign full = r_state == IS_DEC && w_full;
endmodule

// File: rtl/neighbor_builder.sv
// neighbor_builder: clears every neighbour slot, then walks the face list and
// inserts both directions of each edge without duplicates.
module neighbor_builder #(
    parameter int MAX_NEIGHBOR_COUNT = 10,
    parameter int ADDR_WIDTH = subdiv_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           vertex_count,
    input  logic [31:0]           face_count,
    input  logic [31:0]           RAM_OBJ_Do,
    input  logic [31:0]           RAM_NBR_Do,
    output logic                  RAM_OBJ_EN,
    output logic                  RAM_NBR_EN,
    output logic [ADDR_WIDTH-1:0] RAM_OBJ_A,
    output logic [ADDR_WIDTH-1:0] RAM_NBR_A,
    output logic [3:0]            RAM_OBJ_WE,
    output logic [3:0]            RAM_NBR_WE,
    output logic [31:0]           RAM_OBJ_Di,
    output logic [31:0]           RAM_NBR_Di,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic                  bad_index
);
    import subdiv_pkg::*;

    state_e r_state, w_next;
    logic [31:0] r_v, r_f, r_a, r_b, r_c, w_u, w_w, w_ins_di;
    logic [1:0]  r_k;
    logic [2:0]  r_e;
    logic        w_ack, w_full, w_fbad, w_last, w_ins_en, w_clr, w_ins;
    logic [ADDR_WIDTH-1:0] w_ins_a;
    logic [3:0]  w_ins_we;

    assign w_clr  = r_state == ST_CLEAR;
    assign w_ins  = r_state == ST_INS;
    assign w_fbad = r_a == 32'd0 || r_b == 32'd0 || r_c == 32'd0 ||
                    r_a > vertex_count || r_b > vertex_count || r_c > vertex_count;
    assign w_last = r_f + 32'd1 == face_count;
    // Insert order a->b, b->a, b->c, c->b, c->a, a->c.
    assign w_u = (r_e == 3'd0 || r_e == 3'd5) ? r_a : (r_e <= 3'd2) ? r_b : r_c;
    assign w_w = (r_e == 3'd1 || r_e == 3'd4) ? r_a : (r_e == 3'd0 || r_e == 3'd3) ? r_b : r_c;

    nbr_insert #(.MAX_NEIGHBOR_COUNT(MAX_NEIGHBOR_COUNT), .ADDR_WIDTH(ADDR_WIDTH)) u_ins (
        .clk(clk), .rst(rst), .req(w_ins), .u(w_u), .w(w_w), .RAM_NBR_Do(RAM_NBR_Do),
        .ack(w_ack), .full(w_full), .en(w_ins_en), .a(w_ins_a), .we(w_ins_we), .di(w_ins_di)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_next = (vertex_count == 32'd0) ? ST_DONE : ST_CLEAR;
            ST_CLEAR:   if (r_v == vertex_count - 32'd1) w_next = (face_count == 32'd0) ? ST_DONE : ST_FACE_RD;
            ST_FACE_RD: if (r_k == 2'd3) w_next = !w_fbad ? ST_INS : w_last ? ST_DONE : ST_FACE_RD;
            ST_INS:     if (w_ack && r_e == 3'd5) w_next = w_last ? ST_DONE : ST_FACE_RD;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_v       <= '0;
            r_f       <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_k       <= '0;
            r_e       <= '0;
            overflow  <= 1'b0;
            bad_index <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: if (start) begin
                    r_v       <= '0;
                    r_f       <= '0;
                    r_k       <= '0;
                    overflow  <= 1'b0;
                    bad_index <= 1'b0;
                end
                ST_CLEAR: r_v <= r_v + 32'd1;
                ST_FACE_RD: begin
                    r_k <= r_k + 2'd1;
                    r_e <= '0;
                    if (r_k == 2'd0) r_a <= RAM_OBJ_Do;
                    if (r_k == 2'd1) r_b <= RAM_OBJ_Do;
                    if (r_k == 2'd2) r_c <= RAM_OBJ_Do;
                    if (r_k == 2'd3 && w_fbad) begin
                        bad_index <= 1'b1;
                        r_f       <= r_f + 32'd1;
                    end
                end
                ST_INS: if (w_ack) begin
                    r_e <= r_e + 3'd1;
                    if (w_full) overflow <= 1'b1;
                    if (r_e == 3'd5) r_f <= r_f + 32'd1;
                end
                default: ;
            endcase
        end
    end

    assign RAM_OBJ_EN = r_state == ST_FACE_RD && r_k != 2'd3;
    assign RAM_OBJ_A  = RAM_OBJ_EN ? ADDR_WIDTH'(vtx_addr(vertex_count + 32'd1) + 32'd3 * r_f + 32'(r_k)) : '0;
    assign RAM_OBJ_WE = 4'h0;
    assign RAM_OBJ_Di = 32'd0;
    assign RAM_NBR_EN = w_clr || (w_ins && w_ins_en);
    assign RAM_NBR_A  = w_clr ? ADDR_WIDTH'(slot_base(r_v + 32'd1, MAX_NEIGHBOR_COUNT)) :
                        (w_ins && w_ins_en) ? w_ins_a : '0;
    assign RAM_NBR_WE = w_clr ? 4'hF : w_ins ? w_ins_we : 4'h0;
    assign RAM_NBR_Di = w_ins ? w_ins_di : 32'd0;
    assign busy       = w_clr || r_state == ST_FACE_RD || w_ins;
    assign done       = r_state == ST_DONE;
endmodule

// File: tb/tb_neighbor_builder.sv
// tb_neighbor_builder: directed table plus random meshes against a list-based
// neighbour model, with RAM models clocked on posedge.
module tb_neighbor_builder;
    localparam int MAXN = 4;
    localparam int AW = 9;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [31:0] vertex_count = '0, face_count = '0, obj_do = '0, nbr_do = '0;
    logic obj_en, nbr_en, busy, done, overflow, bad_index;
    logic [AW-1:0] obj_a, nbr_a;
    logic [3:0] obj_we, nbr_we;
    logic [31:0] obj_di, nbr_di;

    neighbor_builder #(.MAX_NEIGHBOR_COUNT(MAXN), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .vertex_count(vertex_count), .face_count(face_count),
        .RAM_OBJ_Do(obj_do), .RAM_NBR_Do(nbr_do), .RAM_OBJ_EN(obj_en), .RAM_NBR_EN(nbr_en),
        .RAM_OBJ_A(obj_a), .RAM_NBR_A(nbr_a), .RAM_OBJ_WE(obj_we), .RAM_NBR_WE(nbr_we),
        .RAM_OBJ_Di(obj_di), .RAM_NBR_Di(nbr_di), .busy(busy), .done(done),
        .overflow(overflow), .bad_index(bad_index)
    );

    always #5 clk = ~clk;

    logic [31:0] obj_mem [0:511];
    logic [31:0] nbr_mem [0:511];
    int obj_viol = 0;

    always @(posedge clk) begin
        if (obj_en) obj_do <= obj_mem[obj_a];
        if (nbr_en) begin
            if (nbr_we == 4'hF) nbr_mem[nbr_a] <= nbr_di;
            else if (nbr_we == 4'h0) nbr_do <= nbr_mem[nbr_a];
        end
        if (obj_we != 4'h0 || obj_di != 32'd0) obj_viol <= obj_viol + 1;
    end

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [31:0] fa [0:15], fb [0:15], fc [0:15];
    int          m_cnt [1:16];
    logic [31:0] m_nb  [1:16][1:8];
    bit          m_ovf, m_bad;

    // Reference: each vertex keeps an ordered list; append unless present or full.
    function automatic void model(input int vc, input int nf);
        logic [31:0] us [6];
        logic [31:0] ws [6];
        for (int v = 1; v <= 16; v++) m_cnt[v] = 0;
        m_ovf = 0;
        m_bad = 0;
        if (vc == 0) return;
        for (int f = 0; f < nf; f++) begin
            if (fa[f] == 0 || fb[f] == 0 || fc[f] == 0 ||
                fa[f] > 32'(vc) || fb[f] > 32'(vc) || fc[f] > 32'(vc)) begin
                m_bad = 1;
                continue;
            end
            us = '{fa[f], fb[f], fb[f], fc[f], fc[f], fa[f]};
            ws = '{fb[f], fa[f], fc[f], fb[f], fa[f], fc[f]};
            for (int e = 0; e < 6; e++) begin
                int  u;
                bit  found;
                u = int'(us[e]);
                found = 0;
                for (int i = 1; i <= m_cnt[u]; i++) if (m_nb[u][i] == ws[e]) found = 1;
                if (found) continue;
                if (m_cnt[u] == MAXN - 1) m_ovf = 1;
                else begin
                    m_cnt[u]++;
                    m_nb[u][m_cnt[u]] = ws[e];
                end
            end
        end
    endfunction

    task automatic run_build(input int vc, input int nf, input int prefill, input bit restart, input string tag);
        int cyc, dones, gap;
        bit seen;
        for (int i = 0; i < 512; i++) begin
            obj_mem[i] = $urandom;
            nbr_mem[i] = prefill == 0 ? 32'd0 : prefill == 1 ? 32'hFFFF_FFFF : $urandom;
        end
        for (int f = 0; f < nf; f++) begin
            obj_mem[3 * vc + 1 + 3 * f] = fa[f];
            obj_mem[3 * vc + 2 + 3 * f] = fb[f];
            obj_mem[3 * vc + 3 + 3 * f] = fc[f];
        end
        model(vc, nf);
        vertex_count = 32'(vc);
        face_count = 32'(nf);
        @(posedge clk);
        start = 1'b1;
        @(posedge clk);
        start = 1'b0;
        if (vc != 0) chk({tag, " busy_rise"}, {31'd0, busy}, 32'd1);
        dones = 0;
        gap = 0;
        cyc = 0;
        seen = done;
        if (done) dones++;
        while (!seen && cyc < 20000) begin
            start = restart && cyc == 20;
            @(posedge clk);
            cyc++;
            if (done) begin
                dones++;
                seen = 1;
            end else if (!busy) gap++;
        end
        start = 1'b0;
        chk({tag, " done_seen"}, {31'd0, seen}, 32'd1);
        repeat (3) begin
            @(posedge clk);
            if (done) dones++;
        end
        chk({tag, " done_pulses"}, 32'(dones), 32'd1);
        chk({tag, " busy_gap"}, 32'(gap), 32'd0);
        chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
        chk({tag, " bad_index"}, {31'd0, bad_index}, {31'd0, m_bad});
        for (int v = 1; v <= vc; v++) begin
            chk($sformatf("%s slot%0d cnt", tag, v), nbr_mem[(v - 1) * MAXN], 32'(m_cnt[v]));
            for (int i = 1; i <= m_cnt[v]; i++)
                chk($sformatf("%s slot%0d w%0d", tag, v, i), nbr_mem[(v - 1) * MAXN + i], m_nb[v][i]);
        end
    endtask

    typedef struct packed {
        int vc;
        int nf;
        logic [0:3][0:2][31:0] f;
        logic [1:0] prefill;
        logic restart;
        logic ovf;
        logic bad;
        logic [0:5][3:0] cnt;
    } vec_t;

    vec_t tbl [0:6];

    initial begin
        tbl[0] = '{vc: 3, nf: 1, f: '{'{1, 2, 3}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}}, prefill: 2'd0,
                   restart: 1'b0, ovf: 1'b0, bad: 1'b0, cnt: '{4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0}};
        tbl[1] = '{vc: 4, nf: 2, f: '{'{1, 2, 3}, '{1, 3, 4}, '{0, 0, 0}, '{0, 0, 0}}, prefill: 2'd0,
                   restart: 1'b0, ovf: 1'b0, bad: 1'b0, cnt: '{4'd3, 4'd2, 4'd3, 4'd2, 4'd0, 4'd0}};
        tbl[2] = '{vc: 3, nf: 1, f: '{'{1, 2, 3}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}}, prefill: 2'd1,
                   restart: 1'b0, ovf: 1'b0, bad: 1'b0, cnt: '{4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0}};
        tbl[3] = '{vc: 6, nf: 4, f: '{'{1, 2, 3}, '{1, 3, 4}, '{1, 4, 5}, '{1, 5, 6}}, prefill: 2'd0,
                   restart: 1'b0, ovf: 1'b1, bad: 1'b0, cnt: '{4'd3, 4'd2, 4'd3, 4'd3, 4'd3, 4'd2}};
        tbl[4] = '{vc: 3, nf: 2, f: '{'{0, 2, 3}, '{1, 2, 3}, '{0, 0, 0}, '{0, 0, 0}}, prefill: 2'd2,
                   restart: 1'b1, ovf: 1'b0, bad: 1'b1, cnt: '{4'd2, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0}};
        tbl[5] = '{vc: 3, nf: 0, f: '{'{1, 2, 3}, '{0, 0, 0}, '{0, 0, 0}, '{0, 0, 0}}, prefill: 2'd1,
                   restart: 1'b0, ovf: 1'b0, bad: 1'b0, cnt: '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};
        tbl[6] = '{vc: 0, nf: 2, f: '{'{1, 2, 3}, '{0, 2, 3}, '{0, 0, 0}, '{0, 0, 0}}, prefill: 2'd0,
                   restart: 1'b0, ovf: 1'b0, bad: 1'b0, cnt: '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0}};

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset flags", {30'd0, overflow, bad_index}, 32'd0);
        chk("reset enables", {29'd0, obj_en, nbr_en, |nbr_we}, 32'd0);
        @(posedge clk);
        rst = 1'b0;

        for (int t = 0; t < 7; t++) begin
            for (int f = 0; f < 4; f++) begin
                fa[f] = tbl[t].f[f][0];
                fb[f] = tbl[t].f[f][1];
                fc[f] = tbl[t].f[f][2];
            end
            run_build(tbl[t].vc, tbl[t].nf, int'(tbl[t].prefill), tbl[t].restart, $sformatf("vec%0d", t));
            chk($sformatf("vec%0d tbl_ovf", t), {31'd0, overflow}, {31'd0, tbl[t].ovf});
            chk($sformatf("vec%0d tbl_bad", t), {31'd0, bad_index}, {31'd0, tbl[t].bad});
            for (int v = 1; v <= tbl[t].vc; v++)
                chk($sformatf("vec%0d tbl_cnt%0d", t, v), nbr_mem[(v - 1) * MAXN], {28'd0, tbl[t].cnt[v - 1]});
        end

        begin : reset_mid_build
            bit hit;
            fa[0] = 1; fb[0] = 2; fc[0] = 3;
            vertex_count = 3;
            face_count = 1;
            for (int i = 0; i < 512; i++) nbr_mem[i] = 32'd0;
            for (int i = 0; i < 3; i++) obj_mem[10 + i] = 32'(i + 1);
            @(posedge clk);
            start = 1'b1;
            @(posedge clk);
            start = 1'b0;
            hit = 0;
            for (int c = 0; c < 2000 && !hit; c++) begin
                @(posedge clk);
                hit = nbr_en && nbr_we == 4'h0 && (int'(nbr_a) % MAXN) != 0;
            end
            chk("midrst scan_reached", {31'd0, hit}, 32'd1);
            rst = 1'b1;
            #1;
            chk("midrst status", {28'd0, busy, done, overflow, bad_index}, 32'd0);
            chk("midrst ram_ctl", {22'd0, obj_en, nbr_en, obj_we, nbr_we}, 32'd0);
            chk("midrst addr", {14'd0, obj_a, nbr_a}, 32'd0);
            @(posedge clk);
            rst = 1'b0;
            run_build(3, 1, 2, 1'b0, "after_rst");
        end

        for (int r = 0; r < 12; r++) begin
            int vc, nf;
            vc = int'($urandom_range(3, 8));
            nf = int'($urandom_range(1, 8));
            for (int f = 0; f < nf; f++) begin
                fa[f] = $urandom_range(1, vc);
                do fb[f] = $urandom_range(1, vc); while (fb[f] == fa[f]);
                do fc[f] = $urandom_range(1, vc); while (fc[f] == fa[f] || fc[f] == fb[f]);
                if ($urandom_range(0, 7) == 0) begin
                    logic [31:0] bad;
                    case ($urandom_range(0, 2))
                        0: bad = 32'd0;
                        1: bad = 32'(vc + 1);
                        default: bad = 32'h8000_0001;
                    endcase
                    case ($urandom_range(0, 2))
                        0: fa[f] = bad;
                        1: fb[f] = bad;
                        default: fc[f] = bad;
                    endcase
                end
            end
            run_build(vc, nf, 2, 1'b0, $sformatf("rnd%0d", r));
        end

        chk("obj_ram_never_written", 32'(obj_viol), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
